// File: rtl/adat_rx_adat_pkg.sv
// ---------------------------------------------------------------------------
// adat_rx_adat_pkg
// Shared types and constants for the ADAT receiver output stage.
//   SmuxMode       : S/MUX mode reported to the user-facing interface
//   frame_t        : one complete frame of ADAT_CHANNELS 24-bit samples
//   smux_mode_from_user / channel_count : user-bit decode helpers
// ---------------------------------------------------------------------------
package adat_rx_adat_pkg;

  localparam int ADAT_CHANNELS = 8;
  localparam int SAMPLE_W      = 24;
  localparam int CH_IDX_W      = 3;
  localparam int FRAME_TIME_W  = 12;

  typedef enum logic [1:0] {
    SmuxMode_Standard = 2'd0,
    SmuxMode_Smux2    = 2'd1,
    SmuxMode_Smux4    = 2'd2
  } SmuxMode;

  typedef logic [ADAT_CHANNELS-1:0][SAMPLE_W-1:0] frame_t;

  // Only user bits 2 (S/MUX4) and 1 (S/MUX2) carry mode information;
  // S/MUX4 takes precedence when both are set.
  function automatic SmuxMode smux_mode_from_user(input logic [1:0] mode_bits);
    if (mode_bits[1]) begin
      return SmuxMode_Smux4;
    end else if (mode_bits[0]) begin
      return SmuxMode_Smux2;
    end
    return SmuxMode_Standard;
  endfunction

  // Distinct audio channels carried by the 8 ADAT slots in a given mode.
  function automatic logic [3:0] channel_count(input SmuxMode mode);
    case (mode)
      SmuxMode_Smux2: return 4'd4;
      SmuxMode_Smux4: return 4'd2;
      default:        return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/adat_rx_word_clk_gen.sv
// ---------------------------------------------------------------------------
// adat_rx_word_clk_gen
// Recovers a 50 % duty word clock from the frame publications. A period
// counter restarts on every publication; the clock is high for the first
// half of the measured frame period and low afterwards. If publications
// stop, the counter saturates so the clock parks low.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_frame_time   : measured frame period in i_clk cycles
//   i_restart      : a frame is being published at this edge
//   i_enable       : lock state that will hold after this edge
//   o_word_clk     : registered word clock output
// ---------------------------------------------------------------------------
module adat_rx_word_clk_gen
  import adat_rx_adat_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [FRAME_TIME_W-1:0] i_frame_time,
  input  logic                    i_restart,
  input  logic                    i_enable,
  output logic                    o_word_clk
);

  logic [FRAME_TIME_W-1:0] r_period_cnt;
  logic [FRAME_TIME_W-1:0] w_cnt_next;
  logic [FRAME_TIME_W-1:0] w_half;

  assign w_half = i_frame_time >> 1;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_cnt_next = r_period_cnt;
    if (i_restart) begin
      w_cnt_next = '0;
    end else if (r_period_cnt != '1) begin
      w_cnt_next = r_period_cnt + 1'b1;
    end
  end

  // The clock is derived from the next count so it goes high in the cycle
  // right after a publication, aligned with o_valid.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period_cnt <= '0;
      o_word_clk   <= 1'b0;
    end else begin
      r_period_cnt <= w_cnt_next;
      o_word_clk   <= i_enable && (w_cnt_next < w_half);
    end
  end

endmodule

// File: rtl/adat_rx_output_if.sv
// ---------------------------------------------------------------------------
// adat_rx_output_if
// Final stage of the ADAT receiver. Collects decoded samples into a shadow
// frame buffer, publishes the complete frame when channel 7 arrives, latches
// the S/MUX mode from the user bits, tracks stream lock with a frame-loss
// watchdog and drives a recovered word clock.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_frame_time       : measured frame period in i_clk cycles (0 = unknown)
//   i_data, i_channel  : decoded sample and its slot index, qualified by
//   i_data_valid
//   i_sync             : decoder frame-sync indication
//   i_user_bits        : ADAT user bits of the current frame
//   o_smux_mode        : S/MUX mode of the last published frame
//   o_word_clk         : recovered word clock
//   o_channels         : last complete frame, slot 0..7
//   o_valid            : one-cycle pulse after o_channels updates
//   o_locked           : stream locked
//   o_valid_channels   : distinct audio channels carried (8, 4 or 2)
// ---------------------------------------------------------------------------
module adat_rx_output_if
  import adat_rx_adat_pkg::*;
#(
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT_MULT = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [FRAME_TIME_W-1:0] i_frame_time,
  input  logic [SAMPLE_W-1:0]     i_data,
  input  logic [CH_IDX_W-1:0]     i_channel,
  input  logic                    i_data_valid,
  input  logic                    i_sync,
  input  logic [3:0]              i_user_bits,
  output SmuxMode                 o_smux_mode,
  output logic                    o_word_clk,
  output frame_t                  o_channels,
  output logic                    o_valid,
  output logic                    o_locked,
  output logic [3:0]              o_valid_channels
);

  localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);
  localparam int WD_W   = FRAME_TIME_W + $clog2(TIMEOUT_MULT + 1);

  frame_t            r_shadow;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [WD_W-1:0]   r_wd_cnt;

  frame_t            w_frame;
  logic              w_publish;
  SmuxMode           w_mode;
  logic [WD_W-1:0]   w_wd_limit;
  logic              w_wd_expire;
  logic [LOCK_W-1:0] w_lock_cnt_next;
  logic              w_locked_next;
  logic              w_unused_user_bits;

  // User bits 3 and 0 carry no mode information.
  assign w_unused_user_bits = i_user_bits[3] ^ i_user_bits[0];

  assign w_publish = i_data_valid && (i_channel == CH_IDX_W'(ADAT_CHANNELS - 1));
  assign w_mode    = smux_mode_from_user(i_user_bits[2:1]);

  // Slots 0..6 come from the shadow; slot 7 bypasses it so the frame is
  // published at the same edge that captures channel 7.
  always_comb begin
    w_frame                    = r_shadow;
    w_frame[ADAT_CHANNELS - 1] = i_data;
  end

  // Watchdog fires once TIMEOUT_MULT*i_frame_time cycles have elapsed
  // without a publication; a zero frame time disables it.
  assign w_wd_limit  = WD_W'(i_frame_time) * WD_W'(TIMEOUT_MULT);
  assign w_wd_expire = (i_frame_time != '0) && (r_wd_cnt >= w_wd_limit - WD_W'(1));

  // Loss of sync clears the lock even on a publication cycle; a publication
  // takes precedence over a coincident watchdog expiry.
  always_comb begin
    w_lock_cnt_next = r_lock_cnt;
    if (!i_sync) begin
      w_lock_cnt_next = '0;
    end else if (w_publish) begin
      if (r_lock_cnt != LOCK_W'(LOCK_FRAMES)) begin
        w_lock_cnt_next = r_lock_cnt + 1'b1;
      end
    end else if (w_wd_expire) begin
      w_lock_cnt_next = '0;
    end
  end

  assign w_locked_next = (w_lock_cnt_next == LOCK_W'(LOCK_FRAMES));

  // NOTE: the shadow frame buffer is reset along with the control state so a
  // reset mid-frame cannot leak stale samples into the next publication.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow         <= '0;
      r_lock_cnt       <= '0;
      r_wd_cnt         <= '0;
      o_channels       <= '0;
      o_valid          <= 1'b0;
      o_locked         <= 1'b0;
      o_smux_mode      <= SmuxMode_Standard;
      o_valid_channels <= 4'd8;
    end else begin
      o_valid    <= w_publish;
      r_lock_cnt <= w_lock_cnt_next;
      o_locked   <= w_locked_next;

      if (i_data_valid) begin
        r_shadow[i_channel] <= i_data;
      end

      if (w_publish) begin
        o_channels       <= w_frame;
        o_smux_mode      <= w_mode;
        o_valid_channels <= channel_count(w_mode);
        r_wd_cnt         <= '0;
      end else if (r_wd_cnt != '1) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
    end
  end

  adat_rx_word_clk_gen u_word_clk_gen (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_frame_time (i_frame_time),
    .i_restart    (w_publish),
    .i_enable     (w_locked_next),
    .o_word_clk   (o_word_clk)
  );

endmodule

// File: tb/tb_adat_rx_output_if.sv
// ---------------------------------------------------------------------------
// tb_adat_rx_output_if
// Directed bench for the ADAT receiver output stage. A frame model tracks
// every written slot; each channel-7 write queues the expected frame and
// mode, and a monitor pops and compares whenever o_valid is seen.
// ---------------------------------------------------------------------------
module tb_adat_rx_output_if;
  import adat_rx_adat_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [11:0] i_frame_time;
  logic [23:0] i_data;
  logic [2:0]  i_channel;
  logic        i_data_valid;
  logic        i_sync;
  logic [3:0]  i_user_bits;
  SmuxMode     o_smux_mode;
  logic        o_word_clk;
  frame_t      o_channels;
  logic        o_valid;
  logic        o_locked;
  logic [3:0]  o_valid_channels;

  typedef struct {
    frame_t     ch;
    SmuxMode    mode;
    logic [3:0] nch;
  } exp_frame_t;

  exp_frame_t  sb[$];
  logic [23:0] model [8];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 i_clk = ~i_clk;

  adat_rx_output_if #(.LOCK_FRAMES(2), .TIMEOUT_MULT(2)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_frame_time     (i_frame_time),
    .i_data           (i_data),
    .i_channel        (i_channel),
    .i_data_valid     (i_data_valid),
    .i_sync           (i_sync),
    .i_user_bits      (i_user_bits),
    .o_smux_mode      (o_smux_mode),
    .o_word_clk       (o_word_clk),
    .o_channels       (o_channels),
    .o_valid          (o_valid),
    .o_locked         (o_locked),
    .o_valid_channels (o_valid_channels)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  // Writes one slot; a channel-7 write also queues the expected frame.
  task automatic drive_ch(input int ch, input logic [7:0] tag);
    exp_frame_t e;
    i_data_valid = 1'b1;
    i_channel    = ch[2:0];
    i_data       = {8'hAA, tag, ch[7:0]};
    model[ch]    = i_data;
    if (ch == 7) begin
      for (int i = 0; i < 8; i++) e.ch[i] = model[i];
      if (i_user_bits[2]) begin
        e.mode = SmuxMode_Smux4; e.nch = 4'd2;
      end else if (i_user_bits[1]) begin
        e.mode = SmuxMode_Smux2; e.nch = 4'd4;
      end else begin
        e.mode = SmuxMode_Standard; e.nch = 4'd8;
      end
      sb.push_back(e);
    end
    tick();
    i_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tag);
    for (int ch = 0; ch < 8; ch++) drive_ch(ch, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   64'(o_valid), 64'd0);
    check({tag, "_locked"},  64'(o_locked), 64'd0);
    check({tag, "_wclk"},    64'(o_word_clk), 64'd0);
    check({tag, "_smux"},    64'(o_smux_mode), 64'(SmuxMode_Standard));
    check({tag, "_nch"},     64'(o_valid_channels), 64'd8);
    check({tag, "_chzero"},  64'(o_channels == '0), 64'd1);
  endtask

  // Scoreboard monitor: every o_valid pulse must match a queued frame.
  always @(negedge i_clk) begin
    if (i_rst === 1'b0 && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_frame_t e;
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) check($sformatf("frame_slot%0d", i), 64'(o_channels[i]), 64'(e.ch[i]));
        check("frame_mode", 64'(o_smux_mode), 64'(e.mode));
        check("frame_nch",  64'(o_valid_channels), 64'(e.nch));
      end
    end
  end

  initial begin
    i_rst        = 1'b1;
    i_frame_time = 12'd2048;
    i_data       = '0;
    i_channel    = '0;
    i_data_valid = 1'b0;
    i_sync       = 1'b1;
    i_user_bits  = 4'b0000;
    clear_model();
    tick();
    tick();
    check_reset_outputs("reset");
    i_rst = 1'b0;
    tick();

    // Standard mode: lock after the second frame.
    send_frame(8'h00);
    check("f1_valid",  64'(o_valid), 64'd1);
    check("f1_locked", 64'(o_locked), 64'd0);
    check("f1_wclk",   64'(o_word_clk), 64'd0);
    tick();
    check("f1_valid_low", 64'(o_valid), 64'd0);
    send_frame(8'h00);
    check("f2_locked", 64'(o_locked), 64'd1);
    check("f2_wclk",   64'(o_word_clk), 64'd1);
    tick();
    for (int f = 0; f < 3; f++) begin
      send_frame(8'h00);
      tick();
    end
    check("std_locked", 64'(o_locked), 64'd1);
    check("std_smux",   64'(o_smux_mode), 64'(SmuxMode_Standard));
    check("std_nch",    64'(o_valid_channels), 64'd8);

    // Out-of-order, repeated and missing slots; only ch7 publishes.
    drive_ch(3, 8'h55);
    check("ooo_no_pub", 64'(o_valid), 64'd0);
    drive_ch(0, 8'h55);
    drive_ch(3, 8'h66);
    drive_ch(7, 8'h55);
    check("ooo_pub", 64'(o_valid), 64'd1);
    tick();

    // S/MUX2 after a reset pulse.
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    clear_model();
    i_user_bits = 4'b0010;
    for (int f = 0; f < 5; f++) begin
      send_frame(8'h20 + 8'(f));
      tick();
    end
    check("smux2_locked", 64'(o_locked), 64'd1);
    check("smux2_mode",   64'(o_smux_mode), 64'(SmuxMode_Smux2));
    check("smux2_nch",    64'(o_valid_channels), 64'd4);

    // S/MUX4: mode only changes at publication.
    i_user_bits = 4'b0100;
    for (int ch = 0; ch < 4; ch++) drive_ch(ch, 8'h40);
    check("smux4_hold", 64'(o_smux_mode), 64'(SmuxMode_Smux2));
    for (int ch = 4; ch < 8; ch++) drive_ch(ch, 8'h40);
    check("smux4_mode", 64'(o_smux_mode), 64'(SmuxMode_Smux4));
    check("smux4_nch",  64'(o_valid_channels), 64'd2);
    tick();
    i_user_bits = 4'b0110;
    for (int f = 0; f < 2; f++) begin
      send_frame(8'h41 + 8'(f));
      tick();
    end
    check("smux46_mode", 64'(o_smux_mode), 64'(SmuxMode_Smux4));
    check("smux46_nch",  64'(o_valid_channels), 64'd2);

    // Sync loss drops lock the next cycle; two frames re-lock.
    i_sync = 1'b0;
    tick();
    check("sync_drop_locked", 64'(o_locked), 64'd0);
    check("sync_drop_wclk",   64'(o_word_clk), 64'd0);
    i_sync = 1'b1;
    send_frame(8'h60);
    check("relock1_locked", 64'(o_locked), 64'd0);
    tick();
    send_frame(8'h61);
    check("relock2_locked", 64'(o_locked), 64'd1);
    tick();

    // Word clock shape and watchdog with a 16-cycle frame time.
    i_frame_time = 12'd16;
    send_frame(8'h77);
    check("wclk_p0", 64'(o_word_clk), 64'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("wclk_p%0d", k), 64'(o_word_clk), 64'd1);
    end
    tick();
    check("wclk_p8_low", 64'(o_word_clk), 64'd0);
    for (int k = 9; k < 31; k++) tick();
    tick();
    check("wd_p31_locked", 64'(o_locked), 64'd1);
    tick();
    tick();
    check("wd_p33_locked", 64'(o_locked), 64'd0);
    check("wd_p33_wclk",   64'(o_word_clk), 64'd0);

    // Asynchronous reset mid-frame discards the partial frame.
    i_frame_time = 12'd2048;
    i_user_bits  = 4'b0010;
    send_frame(8'h80);
    tick();
    send_frame(8'h81);
    check("prerst_locked", 64'(o_locked), 64'd1);
    tick();
    for (int ch = 0; ch < 4; ch++) drive_ch(ch, 8'h90);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    tick();
    i_rst = 1'b0;
    i_user_bits = 4'b0000;
    for (int ch = 4; ch < 8; ch++) drive_ch(ch, 8'h99);
    check("postrst_valid", 64'(o_valid), 64'd1);
    tick();
    check("postrst_locked", 64'(o_locked), 64'd0);

    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
